lsu_bus_master: RTL and testbench

- Core-side initiator for the unified word-addressed data memory.
- Accepts one load/store request at a time from the execute stage.
- Aligned, legal requests: issues a single word access with byte strobes, then returns sign/zero-extended load data or a store completion.
- Misaligned or illegal requests: rejected without touching memory.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu_bus_master.sv | 176 +++++++++++++++++
 tb/tb_lsu_bus_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the LSU bus master: size codes, FSM states,
// byte-strobe / lane-replication generation and the alignment check.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    function automatic logic [3:0] gen_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] s;
        case (size)
            SZ_BYTE: s = 4'b0001 << addr_lo;
            SZ_HALF: s = 4'b0011 << {addr_lo[1], 1'b0};
            SZ_WORD: s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] gen_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] w;
        case (size)
            SZ_BYTE: w = {4{wdata[7:0]}};
            SZ_HALF: w = {2{wdata[15:0]}};
            default: w = wdata;
        endcase
        return w;
    endfunction

    // Illegal size is folded in so the accept path has a single reject condition.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = addr_lo[0];
            SZ_WORD: m = (addr_lo != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data alignment: pick the addressed byte/half lane out of the memory
// word and sign- or zero-extend it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            SZ_HALF: data = {{16{~is_unsigned & half_v[15]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store initiator for the word-addressed data memory.
// Optional bus timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    lsu_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       load_data;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

    lsu_load_align u_align (
        .rdata       (mem_rdata),
        .addr_lo     (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        lane_d       = lane_q;
        size_d       = size_q;
        uns_d        = uns_q;
`ifdef LSU_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    lane_d = req_addr[1:0];
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ST_BUS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wstrb_d = req_we ? gen_strobe(req_size, req_addr[1:0]) : 4'b0000;
                        mem_wdata_d = req_we ? gen_wdata(req_size, req_wdata) : 32'h0;
`ifdef LSU_TIMEOUT_EN
                        tmo_d       = '0;
`endif
                    end
                end
            end
            ST_BUS: begin
                if (mem_ack) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_wstrb_d  = 4'b0000;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_we_q ? 32'h0 : load_data;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo_q == TMO_MAX) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_wstrb_d  = 4'b0000;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= 4'b0000;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            lane_q       <= 2'b00;
            size_q       <= SZ_WORD;
            uns_q        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
`ifdef LSU_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: loads/stores of each size, rejects,
// ack delay, mid-access reset and (with LSU_TIMEOUT_EN) bus timeout.
module tb_lsu_bus_master;

`ifdef LSU_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_unsigned, mem_ack;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int n_cmp = 0;
    int n_err = 0;

    lsu_bus_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one accepting edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rd);
        mem_ack = 1'b1; mem_rdata = rd;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        step(); step();
        chk("rst_ready", req_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_rdata", resp_rdata, 0);
        rst_n = 1'b1;
        step();

        // Word load 0x100, ack in first BUS cycle
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        chk("lw_mem_req", mem_req, 1);
        chk("lw_addr", mem_addr, 32'h100);
        chk("lw_wstrb", mem_wstrb, 4'b0000);
        chk("lw_we", mem_we, 0);
        chk("lw_ready_busy", req_ready, 0);
        chk("lw_no_early_resp", resp_valid, 0);
        ack(32'hDEADBEEF);
        chk("lw_resp_valid", resp_valid, 1);
        chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
        chk("lw_err", resp_err, 0);
        chk("lw_req_drop", mem_req, 0);
        step();
        chk("lw_resp_pulse", resp_valid, 0);
        chk("lw_ready_back", req_ready, 1);
        chk("lw_rdata_hold", resp_rdata, 32'hDEADBEEF);

        // Signed byte load 0x103 issued back-to-back in the IDLE cycle
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        chk("lb_addr", mem_addr, 32'h100);
        chk("lb_wstrb", mem_wstrb, 4'b0000);
        ack(32'h80FF0000);
        chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
        step();
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        ack(32'h80FF0000);
        chk("lbu_rdata", resp_rdata, 32'h00000080);
        step();

        // Half loads: signed lane 0, unsigned lane 1
        issue(1'b0, 2'd1, 1'b0, 32'h100, 32'h0);
        ack(32'h1234F00D);
        chk("lh_rdata", resp_rdata, 32'hFFFFF00D);
        step();
        issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
        ack(32'h80015555);
        chk("lhu_rdata", resp_rdata, 32'h00008001);
        step();

        // Half store 0x202
        issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD);
        chk("sh_addr", mem_addr, 32'h200);
        chk("sh_wstrb", mem_wstrb, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hABCDABCD);
        chk("sh_we", mem_we, 1);
        ack(32'hFFFFFFFF);
        chk("sh_resp_valid", resp_valid, 1);
        chk("sh_rdata", resp_rdata, 0);
        chk("sh_err", resp_err, 0);
        step();

        // Byte store 0x101
        issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h00000055);
        chk("sb_wstrb", mem_wstrb, 4'b0010);
        chk("sb_wdata", mem_wdata, 32'h55555555);
        ack(32'h0);
        step();

        // Ack while IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_ignored", resp_valid, 0);
        chk("idle_ack_noreq", mem_req, 0);

        // Misaligned word load 0x301
        issue(1'b0, 2'd2, 1'b0, 32'h301, 32'h0);
        chk("mis_mem_req", mem_req, 0);
        chk("mis_resp_valid", resp_valid, 1);
        chk("mis_err", resp_err, 1);
        chk("mis_rdata", resp_rdata, 0);
        step();
        chk("mis_pulse", resp_valid, 0);
        chk("mis_err_hold", resp_err, 1);

        // Misaligned half and illegal size
        issue(1'b1, 2'd1, 1'b0, 32'h201, 32'h0);
        chk("mish_mem_req", mem_req, 0);
        chk("mish_err", resp_err, 1);
        step();
        issue(1'b0, 2'd3, 1'b0, 32'h400, 32'h0);
        chk("ill_mem_req", mem_req, 0);
        chk("ill_valid", resp_valid, 1);
        chk("ill_err", resp_err, 1);
        step();

        // Word store with 5 wait cycles; stray requests must be ignored
        issue(1'b1, 2'd2, 1'b0, 32'h500, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = 32'h900 + 32'(i * 4); req_we = 1'b0;
            chk($sformatf("wait%0d_req", i), mem_req, 1);
            chk($sformatf("wait%0d_addr", i), mem_addr, 32'h500);
            chk($sformatf("wait%0d_wstrb", i), mem_wstrb, 4'b1111);
            chk($sformatf("wait%0d_wdata", i), mem_wdata, 32'hCAFEF00D);
            chk($sformatf("wait%0d_ready", i), req_ready, 0);
            chk($sformatf("wait%0d_resp", i), resp_valid, 0);
            step();
        end
        req_valid = 1'b0;
        chk("wait_final_req", mem_req, 1);
        ack(32'h0);
        chk("wait_resp_valid", resp_valid, 1);
        chk("wait_err_clear", resp_err, 0);
        chk("wait_rdata", resp_rdata, 0);
        step();

        // Reset in second wait cycle abandons the access
        issue(1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
        chk("rstmid_req1", mem_req, 1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstmid_req_drop", mem_req, 0);
        chk("rstmid_no_resp", resp_valid, 0);
        mem_ack = 1'b1; mem_rdata = 32'hAAAAAAAA;
        step();
        mem_ack = 1'b0;
        chk("rstmid_late_ack", resp_valid, 0);
        chk("rstmid_ready", req_ready, 1);
        chk("rstmid_rdata", resp_rdata, 0);

`ifdef LSU_TIMEOUT_EN
        // No ack: timeout after TO BUS cycles
        step();
        issue(1'b0, 2'd2, 1'b0, 32'h700, 32'h0);
        for (int i = 0; i < TO; i++) begin
            chk($sformatf("tmo%0d_req", i), mem_req, 1);
            chk($sformatf("tmo%0d_resp", i), resp_valid, 0);
            step();
        end
        chk("tmo_req_drop", mem_req, 0);
        chk("tmo_valid", resp_valid, 1);
        chk("tmo_err", resp_err, 1);
        chk("tmo_rdata", resp_rdata, 0);
        step();
        chk("tmo_ready", req_ready, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
